// File: rtl/tdm_demux2_pkg.sv
// tdm_demux2_pkg: state encodings and default sample width for the 1:2 TDM demultiplexer.
package tdm_demux2_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SLOT1    = 2'd1,
        SLOT2    = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/tdm_demux2.sv
// tdm_demux2: registered 1:2 time-division demultiplexer with sync-based frame alignment.
module tdm_demux2
    import tdm_demux2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             pair_valid,
    output logic             locked,
    output logic             sync_err
);

    state_t           state, state_d;
    logic [WIDTH-1:0] out1_d, out2_d;
    logic             out1_valid_d, out2_valid_d, pair_valid_d, sync_err_d;

    always_comb begin
        state_d      = state;
        out1_d       = out1;
        out2_d       = out2;
        out1_valid_d = 1'b0;
        out2_valid_d = 1'b0;
        pair_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        case (state)
            UNLOCKED: if (in_valid && in_sync) begin
                out1_d       = in;
                out1_valid_d = 1'b1;
                state_d      = SLOT2;
            end
            SLOT1: if (in_valid) begin
                out1_d       = in;
                out1_valid_d = 1'b1;
                state_d      = SLOT2;
            end
            // A sync on a ch2 slot restarts the pair with this sample as ch1.
            SLOT2: if (in_valid) begin
                if (in_sync) begin
                    out1_d       = in;
                    out1_valid_d = 1'b1;
                    sync_err_d   = 1'b1;
                end else begin
                    out2_d       = in;
                    out2_valid_d = 1'b1;
                    pair_valid_d = 1'b1;
                    state_d      = SLOT1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= UNLOCKED;
            out1       <= '0;
            out2       <= '0;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
            pair_valid <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_d;
            out1       <= out1_d;
            out2       <= out2_d;
            out1_valid <= out1_valid_d;
            out2_valid <= out2_valid_d;
            pair_valid <= pair_valid_d;
            sync_err   <= sync_err_d;
            locked     <= (state_d != UNLOCKED);
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: table-driven directed checks plus reset, discard and random-stream sequences.
module tb_tdm_demux2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] in = '0;
    logic       in_valid = 1'b0;
    logic       in_sync = 1'b0;
    logic [3:0] out1, out2;
    logic       out1_valid, out2_valid, pair_valid, locked, sync_err;

    int errors = 0;
    int checks = 0;
    int pv_count = 0;
    int err_count = 0;

    tdm_demux2 #(.WIDTH(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in(in), .in_valid(in_valid),
        .in_sync(in_sync), .out1(out1), .out2(out2), .out1_valid(out1_valid),
        .out2_valid(out2_valid), .pair_valid(pair_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[12];

    // {out1, out2, out1_valid, out2_valid, pair_valid, locked, sync_err}
    function automatic logic [12:0] pk(input logic [3:0] o1, input logic [3:0] o2,
                                       input logic a, input logic b, input logic c,
                                       input logic l, input logic e);
        return {o1, o2, a, b, c, l, e};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {out1, out2, out1_valid, out2_valid, pair_valid, locked, sync_err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (out1,out2,o1v,o2v,pv,lock,err)", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic v, input logic s, input logic [3:0] d,
                        input logic [12:0] exp);
        in_valid = v;
        in_sync  = s;
        in       = d;
        @(posedge sys_clk);
        #1;
        pv_count  += int'(pair_valid);
        err_count += int'(sync_err);
        check(name, exp);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] m1, m2, d;
        tbl[0]  = '{1, 1, 4'h3, pk(4'h3, 4'h0, 1, 0, 0, 1, 0)};
        tbl[1]  = '{1, 0, 4'hA, pk(4'h3, 4'hA, 0, 1, 1, 1, 0)};
        tbl[2]  = '{1, 1, 4'h5, pk(4'h5, 4'hA, 1, 0, 0, 1, 0)};
        tbl[3]  = '{1, 0, 4'hC, pk(4'h5, 4'hC, 0, 1, 1, 1, 0)};
        tbl[4]  = '{1, 1, 4'h4, pk(4'h4, 4'hC, 1, 0, 0, 1, 0)};
        tbl[5]  = '{0, 0, 4'h0, pk(4'h4, 4'hC, 0, 0, 0, 1, 0)};
        tbl[6]  = '{0, 1, 4'hE, pk(4'h4, 4'hC, 0, 0, 0, 1, 0)};
        tbl[7]  = '{1, 0, 4'h9, pk(4'h4, 4'h9, 0, 1, 1, 1, 0)};
        tbl[8]  = '{1, 1, 4'h1, pk(4'h1, 4'h9, 1, 0, 0, 1, 0)};
        tbl[9]  = '{1, 1, 4'h6, pk(4'h6, 4'h9, 1, 0, 0, 1, 1)};
        tbl[10] = '{1, 0, 4'h2, pk(4'h6, 4'h2, 0, 1, 1, 1, 0)};
        tbl[11] = '{0, 1, 4'hF, pk(4'h6, 4'h2, 0, 0, 0, 1, 0)};

        repeat (2) @(negedge sys_clk);
        check("reset_state", pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        sys_rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].exp);

        do_reset();
        step("discard7", 1, 0, 4'h7, pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        step("discard8", 1, 0, 4'h8, pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        step("lock1", 1, 1, 4'h1, pk(4'h1, 4'h0, 1, 0, 0, 1, 0));
        step("pair2", 1, 0, 4'h2, pk(4'h1, 4'h2, 0, 1, 1, 1, 0));

        do_reset();
        step("mid_ch1", 1, 1, 4'h3, pk(4'h3, 4'h0, 1, 0, 0, 1, 0));
        in_valid = 1'b1;
        in_sync  = 1'b0;
        in       = 4'hB;
        #2 sys_rst_n = 1'b0;
        #1 check("async_reset", pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step("release_discardB", 1, 0, 4'hB, pk(4'h0, 4'h0, 0, 0, 0, 0, 0));

        do_reset();
        pv_count  = 0;
        err_count = 0;
        m1 = 4'h0;
        m2 = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            d = 4'($urandom_range(0, 15));
            if (i % 2 == 0) begin
                m1 = d;
                step($sformatf("rnd%0d", i), 1, 1, d, pk(m1, m2, 1, 0, 0, 1, 0));
            end else begin
                m2 = d;
                step($sformatf("rnd%0d", i), 1, 0, d, pk(m1, m2, 0, 1, 1, 1, 0));
            end
        end
        checks++;
        if (pv_count != 500) begin
            errors++;
            $display("FAIL pair_count: got %0d want 500", pv_count);
        end
        checks++;
        if (err_count != 0) begin
            errors++;
            $display("FAIL sync_err_count: got %0d want 0", err_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
